// File: rtl/output_frame_streamer.sv
// Streams a finished frame out of the NPU output RAM as one pixel per cycle over valid/ready.
// A one-word prefetch buffer sits behind an 8-pixel shift register to hide the RAM read latency.
module output_frame_streamer #(
   parameter int WIDTH       = 640,
   parameter int HEIGHT      = 480,
   parameter bit BORDER_ZERO = 1'b1,
   parameter bit REPEAT      = 1'b0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        output_ready,
   input  logic [63:0] ram_data,
   output logic [15:0] ram_address,
   output logic [7:0]  pix_data,
   output logic        pix_valid,
   input  logic        pix_ready,
   output logic        pix_eol,
   output logic        pix_last,
   output logic        frame_done
);

   localparam logic [15:0] LAST_WORD = 16'(WIDTH * HEIGHT / 8 - 1);
   localparam logic [9:0]  LAST_COL  = 10'(WIDTH - 1);
   localparam logic [8:0]  LAST_ROW  = 9'(HEIGHT - 1);

   typedef enum logic [1:0] {
      IDLE,
      PRIME,
      STREAM,
      DONE
   } state_t;

   state_t state, state_next;

   logic        prime_phase;
   logic [63:0] sh_data;
   logic [63:0] pf_data;
   logic        sh_valid;
   logic        pf_valid;
   logic [2:0]  byte_idx;
   logic [1:0]  rd_pipe;
   logic [9:0]  col;
   logic [8:0]  row;

   logic        xfer;
   logic        at_eol;
   logic        at_last;
   logic        abort;
   logic        prime_load;
   logic        consume_pf;
   logic        frame_end;
   logic        rd_issue;
   logic        addr_load;
   logic [15:0] addr_next;
   logic        border;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Dropping output_ready anywhere outside IDLE flushes everything; this is also how DONE exits.
   always_comb begin
      state_next = state;
      xfer       = sh_valid & pix_ready;
      at_eol     = (col == LAST_COL);
      at_last    = at_eol && (row == LAST_ROW);
      abort      = 1'b0;
      prime_load = 1'b0;
      consume_pf = 1'b0;
      frame_end  = 1'b0;
      rd_issue   = 1'b0;
      addr_load  = 1'b0;
      addr_next  = ram_address;

      case (state)
         IDLE: begin
            if (output_ready) begin
               addr_load  = 1'b1;
               addr_next  = 16'd0;
               state_next = PRIME;
            end
         end
         PRIME: begin
            if (!output_ready) begin
               abort      = 1'b1;
               state_next = IDLE;
            end else if (!prime_phase) begin
               rd_issue  = 1'b1;
               addr_load = 1'b1;
               addr_next = 16'd1;
            end else begin
               prime_load = 1'b1;
               state_next = STREAM;
            end
         end
         STREAM: begin
            if (!output_ready) begin
               abort      = 1'b1;
               state_next = IDLE;
            end else begin
               frame_end = xfer && at_last;
               if (frame_end && !REPEAT) begin
                  state_next = DONE;
               end else if (pf_valid && (!sh_valid || (xfer && byte_idx == 3'd7))) begin
                  consume_pf = 1'b1;
               end
               // Each consumed prefetch word triggers exactly one new read, so one read is in flight at most.
               if (consume_pf) begin
                  if (ram_address == LAST_WORD) begin
                     if (REPEAT) begin
                        rd_issue  = 1'b1;
                        addr_load = 1'b1;
                        addr_next = 16'd0;
                     end
                  end else begin
                     rd_issue  = 1'b1;
                     addr_load = 1'b1;
                     addr_next = ram_address + 16'd1;
                  end
               end
            end
         end
         DONE: begin
            if (!output_ready) begin
               abort      = 1'b1;
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ram_address <= 16'd0;
         prime_phase <= 1'b0;
         sh_data     <= 64'd0;
         pf_data     <= 64'd0;
         sh_valid    <= 1'b0;
         pf_valid    <= 1'b0;
         byte_idx    <= 3'd0;
         rd_pipe     <= 2'b00;
         col         <= 10'd0;
         row         <= 9'd0;
         frame_done  <= 1'b0;
      end else if (abort) begin
         ram_address <= 16'd0;
         prime_phase <= 1'b0;
         sh_valid    <= 1'b0;
         pf_valid    <= 1'b0;
         byte_idx    <= 3'd0;
         rd_pipe     <= 2'b00;
         col         <= 10'd0;
         row         <= 9'd0;
         frame_done  <= 1'b0;
      end else begin
         rd_pipe     <= {rd_pipe[0], rd_issue};
         frame_done  <= frame_end;
         prime_phase <= (state == PRIME) && !prime_phase;

         if (addr_load) begin
            ram_address <= addr_next;
         end

         // The byte-7 transfer and the refill from prefetch share an edge, so consecutive words have no bubble.
         if (prime_load) begin
            sh_data  <= ram_data;
            sh_valid <= 1'b1;
            byte_idx <= 3'd0;
         end else if (consume_pf) begin
            sh_data  <= pf_data;
            sh_valid <= 1'b1;
            byte_idx <= 3'd0;
         end else if (xfer) begin
            if (byte_idx == 3'd7) begin
               sh_valid <= 1'b0;
            end else begin
               byte_idx <= byte_idx + 3'd1;
            end
         end

         if (rd_pipe[1]) begin
            pf_data  <= ram_data;
            pf_valid <= 1'b1;
         end else if (consume_pf) begin
            pf_valid <= 1'b0;
         end

         if (xfer) begin
            if (at_eol) begin
               col <= 10'd0;
               row <= at_last ? 9'd0 : row + 9'd1;
            end else begin
               col <= col + 10'd1;
            end
         end
      end
   end

   always_comb begin
      border    = BORDER_ZERO && (row == 9'd0 || row == LAST_ROW || col == 10'd0 || col == LAST_COL);
      pix_data  = border ? 8'h00 : sh_data[{byte_idx, 3'b000} +: 8];
      pix_valid = sh_valid;
      pix_eol   = sh_valid & at_eol;
      pix_last  = sh_valid & at_last;
   end

endmodule

// File: tb/tb_output_frame_streamer.sv
// Directed bench for output_frame_streamer on a 16x4 frame: one single-shot plain instance and
// one repeating, border-zeroing instance, both fed by a RAM model whose byte k of word n is n+k.
module tb_output_frame_streamer;

   logic        clk;
   logic        reset;
   logic        ready0;
   logic        ready1;
   logic        prdy;
   logic [63:0] ramData0;
   logic [63:0] ramData1;
   logic [15:0] ramAddr0;
   logic [15:0] ramAddr1;
   logic [7:0]  pixData0;
   logic [7:0]  pixData1;
   logic        pixValid0;
   logic        pixValid1;
   logic        pixEol0;
   logic        pixEol1;
   logic        pixLast0;
   logic        pixLast1;
   logic        frameDone0;
   logic        frameDone1;

   logic        selDut;
   logic [7:0]  sData;
   logic        sValid;
   logic        sEol;
   logic        sLast;
   logic        sDone;
   logic [15:0] sAddr;

   int          vectors;
   int          miscompares;
   int          doneSeen;
   bit          sawWrap;
   bit          activity;

   output_frame_streamer #(
      .WIDTH(16), .HEIGHT(4), .BORDER_ZERO(1'b0), .REPEAT(1'b0)
   ) dut0 (
      .clk(clk), .reset(reset), .output_ready(ready0), .ram_data(ramData0),
      .ram_address(ramAddr0), .pix_data(pixData0), .pix_valid(pixValid0),
      .pix_ready(prdy), .pix_eol(pixEol0), .pix_last(pixLast0), .frame_done(frameDone0)
   );

   output_frame_streamer #(
      .WIDTH(16), .HEIGHT(4), .BORDER_ZERO(1'b1), .REPEAT(1'b1)
   ) dut1 (
      .clk(clk), .reset(reset), .output_ready(ready1), .ram_data(ramData1),
      .ram_address(ramAddr1), .pix_data(pixData1), .pix_valid(pixValid1),
      .pix_ready(prdy), .pix_eol(pixEol1), .pix_last(pixLast1), .frame_done(frameDone1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [63:0] ramWord(input logic [15:0] a);
      logic [63:0] w;
      w = 64'd0;
      for (int k = 0; k < 8; k++) begin
         w[8*k +: 8] = a[7:0] + 8'(k);
      end
      return w;
   endfunction

   // One-cycle read latency: the address seen at an edge returns data after that edge.
   always @(posedge clk) begin
      ramData0 <= ramWord(ramAddr0);
      ramData1 <= ramWord(ramAddr1);
   end

   assign sData  = selDut ? pixData1   : pixData0;
   assign sValid = selDut ? pixValid1  : pixValid0;
   assign sEol   = selDut ? pixEol1    : pixEol0;
   assign sLast  = selDut ? pixLast1   : pixLast0;
   assign sDone  = selDut ? frameDone1 : frameDone0;
   assign sAddr  = selDut ? ramAddr1   : ramAddr0;

   function automatic logic [7:0] expPixel(input int idx, input bit border);
      int p;
      int r;
      int c;
      p = idx % 64;
      r = p / 16;
      c = p % 16;
      if (border && (r == 0 || r == 3 || c == 0 || c == 15)) begin
         return 8'h00;
      end
      return 8'((p / 8) + (p % 8));
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      vectors++;
      if (observed !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic waitValid();
      int n;
      n = 0;
      while (!sValid && n < 10) begin
         @(negedge clk);
         n++;
      end
      if (!sValid) begin
         checkOutput("waitValid", 64'(sValid), 64'd1);
      end
   endtask

   // Called at a negedge with the first pixel of interest presented; returns at the negedge after the last transfer.
   task automatic applyStimulus(input bit randomStall, input int nPix);
      int          idx;
      int          cycles;
      bit          stalled;
      logic [7:0]  held;
      logic [15:0] prevAddr;
      idx      = 0;
      cycles   = 0;
      stalled  = 1'b0;
      held     = 8'h00;
      prevAddr = sAddr;
      while (idx < nPix && cycles < 2000) begin
         if (stalled) begin
            checkOutput("stallValid", 64'(sValid), 64'd1);
            checkOutput("stallData", 64'(sData), 64'(held));
         end
         if (sAddr != prevAddr) begin
            if (prevAddr == 16'd7 && sAddr == 16'd0) begin
               sawWrap = 1'b1;
            end
            prevAddr = sAddr;
         end
         if (sDone) begin
            doneSeen++;
         end
         prdy = randomStall ? 1'($urandom_range(0, 1)) : 1'b1;
         if (!randomStall && idx > 0) begin
            checkOutput("noGap", 64'(sValid), 64'd1);
         end
         stalled = sValid && !prdy;
         held    = sData;
         if (sValid && prdy) begin
            checkOutput("pixData", 64'(sData), 64'(expPixel(idx, selDut)));
            checkOutput("pixEol", 64'(sEol), 64'((idx % 16) == 15));
            checkOutput("pixLast", 64'(sLast), 64'((idx % 64) == 63));
            idx++;
         end
         cycles++;
         @(negedge clk);
      end
      if (idx < nPix) begin
         checkOutput("streamTimeout", 64'(idx), 64'(nPix));
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      doneSeen    = 0;
      sawWrap     = 1'b0;
      activity    = 1'b0;
      selDut      = 1'b0;
      reset       = 1'b0;
      ready0      = 1'b0;
      ready1      = 1'b0;
      prdy        = 1'b0;

      #12;
      checkOutput("resetValid", 64'(sValid), 64'd0);
      checkOutput("resetAddr", 64'(sAddr), 64'd0);
      checkOutput("resetData", 64'(sData), 64'd0);
      checkOutput("resetEol", 64'(sEol), 64'd0);
      checkOutput("resetLast", 64'(sLast), 64'd0);
      checkOutput("resetDone", 64'(sDone), 64'd0);

      @(negedge clk);
      reset = 1'b1;
      repeat (20) begin
         @(negedge clk);
         if (pixValid0 || ramAddr0 != 16'd0) begin
            activity = 1'b1;
         end
      end
      checkOutput("idleQuiet", 64'(activity), 64'd0);

      // Start-up latency, then an unstalled frame
      ready0 = 1'b1;
      prdy   = 1'b1;
      @(negedge clk);
      checkOutput("e0Addr", 64'(sAddr), 64'd0);
      checkOutput("e0Valid", 64'(sValid), 64'd0);
      @(negedge clk);
      checkOutput("e1Addr", 64'(sAddr), 64'd1);
      checkOutput("e1Valid", 64'(sValid), 64'd0);
      @(negedge clk);
      checkOutput("e2Valid", 64'(sValid), 64'd1);
      applyStimulus(1'b0, 64);
      checkOutput("frameDone", 64'(sDone), 64'd1);
      checkOutput("doneValid", 64'(sValid), 64'd0);
      checkOutput("doneAddr", 64'(sAddr), 64'd7);
      @(negedge clk);
      checkOutput("donePulseEnd", 64'(sDone), 64'd0);
      checkOutput("doneHold", 64'(sValid), 64'd0);

      // Randomly stalled frame
      ready0 = 1'b0;
      repeat (2) @(negedge clk);
      ready0 = 1'b1;
      prdy   = 1'b1;
      waitValid();
      applyStimulus(1'b1, 64);
      checkOutput("stallFrameDone", 64'(sDone), 64'd1);

      // Abort by dropping output_ready mid-frame
      ready0 = 1'b0;
      repeat (2) @(negedge clk);
      ready0 = 1'b1;
      prdy   = 1'b1;
      waitValid();
      applyStimulus(1'b0, 20);
      ready0 = 1'b0;
      @(negedge clk);
      checkOutput("abortValid", 64'(sValid), 64'd0);
      checkOutput("abortAddr", 64'(sAddr), 64'd0);
      checkOutput("abortDone", 64'(sDone), 64'd0);
      @(negedge clk);
      checkOutput("abortNoDone", 64'(sDone), 64'd0);

      // Asynchronous reset mid-frame, restart with output_ready held high
      ready0 = 1'b1;
      waitValid();
      applyStimulus(1'b0, 40);
      #2 reset = 1'b0;
      #1;
      checkOutput("asyncValid", 64'(sValid), 64'd0);
      checkOutput("asyncAddr", 64'(sAddr), 64'd0);
      checkOutput("asyncData", 64'(sData), 64'd0);
      checkOutput("asyncEol", 64'(sEol), 64'd0);
      @(negedge clk);
      reset = 1'b1;
      waitValid();
      applyStimulus(1'b0, 64);
      checkOutput("restartDone", 64'(sDone), 64'd1);

      // Repeating instance with zeroed border, two back-to-back frames
      ready0   = 1'b0;
      selDut   = 1'b1;
      doneSeen = 0;
      sawWrap  = 1'b0;
      ready1   = 1'b1;
      prdy     = 1'b1;
      @(negedge clk);
      waitValid();
      applyStimulus(1'b0, 128);
      checkOutput("repDone2", 64'(sDone), 64'd1);
      checkOutput("repDone1", 64'(doneSeen), 64'd1);
      checkOutput("repWrap", 64'(sawWrap), 64'd1);
      checkOutput("repNoBubble", 64'(sValid), 64'd1);
      ready1 = 1'b0;
      @(negedge clk);
      checkOutput("repAbort", 64'(sValid), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/output_frame_streamer.md
Name: output_frame_streamer

Overview:
- Downstream neighbour of the NPU output handler. It waits for `output_ready`, then reads the finished 640x480 8-bit frame out of the output RAM through the handler's `ram_address`/`ram_data` port.
- Each 64-bit word is unpacked into 8 pixels and streamed with a valid/ready handshake to the display/transmit logic, one pixel per cycle when not stalled.
- A one-word prefetch buffer hides the RAM read latency.

Parameters:
- WIDTH, 640, pixels per line; WIDTH % 8 == 0.
- HEIGHT, 480, lines per frame; WIDTH*HEIGHT/8 <= 65536.
- BORDER_ZERO, 1, when 1, outer 1-pixel ring (row 0, row HEIGHT-1, col 0, col WIDTH-1) is output as 8'h00; the handler never writes it.
- REPEAT, 0, when 1, restart at word 0 after the last pixel while `output_ready` stays high; when 0, stop after one frame.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- output_ready  in  1  frame complete in output RAM; from the handler, sticky until the handler is reset.
- ram_data  in  64  RAM read data, valid one cycle after the address is sampled; byte k = bits[8k+7:8k] = pixel 8*addr+k.
- ram_address  out  16  registered RAM word address.
- pix_data  out  8  pixel value.
- pix_valid  out  1  pix_data valid.
- pix_ready  in  1  downstream accepts; transfer = pix_valid & pix_ready.
- pix_eol  out  1  qualifies the current pixel as column WIDTH-1.
- pix_last  out  1  qualifies the current pixel as the last pixel of the frame.
- frame_done  out  1  one-cycle pulse after the last pixel transfer.

Behaviour:
- Reset (reset=0, asynchronous) values:
  - ram_address=0, pix_data=0, pix_valid=0, pix_eol=0, pix_last=0, frame_done=0.
  - State IDLE; col=0, row=0; both buffers marked empty.
- States:
  - IDLE: go to PRIME when output_ready=1.
  - PRIME: issue word 0, then word 1, and capture word 0 into the shift register.
  - STREAM: emit pixels.
  - DONE: hold.
- Latency: let E0 be the edge at which IDLE samples output_ready=1.
  - E0: ram_address<=0.
  - E1: RAM samples 0; ram_address<=1.
  - E2: word0 is loaded into the shift register; pix_valid<=1 with pixel 0.
  - E3: word1 is captured into the prefetch buffer; that RAM read was issued at E1.
- Prefetch:
  - Whenever the prefetch buffer is consumed, ram_address increments and the returned word is captured 2 edges later.
  - At most one read is outstanding.
  - No read is issued beyond word WIDTH*HEIGHT/8-1; with REPEAT=1 the address wraps to 0.
- Stream: the shift register emits byte 0 first through byte 7.
  - On the transfer of byte 7, the prefetch buffer loads into the shift register on the same edge, so there is no bubble.
  - If the prefetch buffer is not yet filled, pix_valid drops until it is. With 8 pixels per word this cannot occur unstalled, but it is legal.
- Stall: while pix_valid=1 and pix_ready=0, pix_data, pix_eol and pix_last are held stable and no counters advance.
- Counters: col 0..WIDTH-1 and row 0..HEIGHT-1 advance on each transfer.
  - pix_eol = (col==WIDTH-1).
  - pix_last = pix_eol & (row==HEIGHT-1).
  - col wraps to 0 and row increments on pix_eol transfer.
- BORDER_ZERO=1: pix_data is forced to 0 when row==0, row==HEIGHT-1, col==0 or col==WIDTH-1. RAM data is still consumed.
- Frame end: on transfer of the pix_last pixel, frame_done pulses for 1 cycle at the next edge.
  - REPEAT=0: go to DONE with pix_valid=0, and remain there until output_ready=0, then return to IDLE.
  - REPEAT=1: continue with pixel 0 of word 0 with no bubble; the prefetch has already wrapped.
- output_ready falling in any non-IDLE state: abort at the next edge.
  - pix_valid=0, buffers flushed, counters cleared, ram_address=0, state IDLE.
  - frame_done is not pulsed.
- Asynchronous reset mid-frame: immediate return to reset values. After release, the streamer waits for output_ready again; a sticky-high output_ready starts a new frame from word 0.
- Widths: col is 10 bits, row 9 bits, ram_address 16 bits. Address compare is against the WIDTH*HEIGHT/8-1 constant (38399 by default).

Test Plan:
- Reset release, output_ready=0 for 20 cycles -> pix_valid=0, ram_address=0, no reads issued.
- output_ready=1 at E0, pix_ready=1, RAM model word n = {8{n[7:0]}} + byte index, BORDER_ZERO=0 -> ram_address 0 at E0, 1 at E1; pix_valid at E2; pixels 0..15 = 00..07, 01..08 with no gaps.
- Full frame, pix_ready=1, BORDER_ZERO=1 -> 307200 transfers; 480 pix_eol; single pix_last at transfer 307199; frame_done 1 cycle later; row 0, row 479, col 0 and col 639 all 00; pix_valid=0 in DONE.
- pix_ready random 50% -> pix_data held during every stall; byte sequence identical to unstalled run; max one outstanding read.
- REPEAT=1, two frames -> pixel 0 of frame 2 immediately follows pix_last; ram_address wraps 38399->0; frame_done pulses twice.
- reset asserted at pixel 1000, released with output_ready=1 -> outputs zero asynchronously; restart streams pixel 0 from word 0. output_ready dropped mid-frame -> pix_valid=0 next edge, no frame_done.
